// File: rtl/lc2k_pkg.sv
// lc2k_pkg: shared LC2K writeback constants and the pending-write entry type.
package lc2k_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DEF_DATA_W-1:0] value;
    } lc2k_entry_t;

endpackage

// File: rtl/lc2k_wb_fifo.sv
// lc2k_wb_fifo: circular pending-write queue exposing every entry for operand forwarding.
module lc2k_wb_fifo
    import lc2k_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2,
    parameter int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_push,
    input  logic                              i_pop,
    input  logic [REG_ADDR_W-1:0]             i_push_dest,
    input  logic [DATA_W-1:0]                 i_push_value,
    output logic [CW-1:0]                     o_count,
    output logic [PW-1:0]                     o_head,
    output logic [DEPTH-1:0]                  o_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]  o_dest,
    output logic [DEPTH-1:0][DATA_W-1:0]      o_value
);

    logic [CW-1:0]                    r_count;
    logic [PW-1:0]                    r_head;
    logic [PW-1:0]                    r_tail;
    logic [DEPTH-1:0]                 r_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] r_dest;
    logic [DEPTH-1:0][DATA_W-1:0]     r_value;
    logic                             w_push;
    logic                             w_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Never overfill or underflow, whatever the caller asks for.
    assign w_push = i_push && (r_count != CW'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    // Pointers, occupancy and per-entry valid bits; dropped asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= f_next(r_head);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= f_next(r_tail);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Payload storage needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dest[r_tail]  <= i_push_dest;
            r_value[r_tail] <= i_push_value;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_dest  = r_dest;
    assign o_value = r_value;

endmodule

// File: rtl/lc2k_writeback.sv
// lc2k_writeback: queued register-file writeback with youngest-first operand forwarding.
module lc2k_writeback
    import lc2k_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0]     in_value,
    input  logic                  wb_stall,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_value,
    output logic                  CONTROL_ENABLE_REG_WRITE,
    input  logic [REG_ADDR_W-1:0] read_regA,
    input  logic [REG_ADDR_W-1:0] read_regB,
    input  logic [DATA_W-1:0]     rf_valA,
    input  logic [DATA_W-1:0]     rf_valB,
    output logic [DATA_W-1:0]     aluValA,
    output logic [DATA_W-1:0]     regBvalue,
    output logic [1:0]            pending,
    output logic [15:0]           wb_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]                    w_count;
    logic [PW-1:0]                    w_head;
    logic [DEPTH-1:0]                 w_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] w_dest;
    logic [DEPTH-1:0][DATA_W-1:0]     w_value;
    logic [PW-1:0]                    w_age [DEPTH];
    logic                             w_push;
    logic                             w_busy;
    logic                             w_pop;
    logic [REG_ADDR_W-1:0]            w_head_dest;
    logic [DATA_W-1:0]                w_fwd_a;
    logic [DATA_W-1:0]                w_fwd_b;
    logic [15:0]                      r_wb_count;

    // A full queue refuses input even if the head drains this same cycle.
    assign in_ready = w_count < CW'(DEPTH);
    assign w_push   = in_valid && in_ready;

    lc2k_wb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PW     (PW),
        .CW     (CW)
    ) u_fifo (
        .clk          (clk),
        .rst          (reset),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_push_dest  (in_dest),
        .i_push_value (in_value),
        .o_count      (w_count),
        .o_head       (w_head),
        .o_valid      (w_valid),
        .o_dest       (w_dest),
        .o_value      (w_value)
    );

    // Head entry drives the write port; r0 entries drain without a strobe.
    assign w_busy                   = w_count != '0;
    assign w_head_dest              = w_dest[w_head];
    assign w_pop                    = w_busy && !wb_stall;
    assign write_reg                = w_busy ? w_head_dest : '0;
    assign write_value              = w_busy ? w_value[w_head] : '0;
    assign CONTROL_ENABLE_REG_WRITE = w_pop && (w_head_dest != '0);
    assign pending                  = 2'(w_count);

    // Slot index of the k-th oldest entry, so later matches mean younger data.
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign w_age[g] = PW'((int'(w_head) + g) % DEPTH);
    end

    // Scan oldest to youngest so the youngest matching pending write wins.
    always_comb begin
        w_fwd_a = rf_valA;
        w_fwd_b = rf_valB;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_valid[w_age[k]] && (w_dest[w_age[k]] != '0) && (w_dest[w_age[k]] == read_regA))
                w_fwd_a = w_value[w_age[k]];
            if (w_valid[w_age[k]] && (w_dest[w_age[k]] != '0) && (w_dest[w_age[k]] == read_regB))
                w_fwd_b = w_value[w_age[k]];
        end
    end

    assign aluValA   = (read_regA == '0) ? '0 : w_fwd_a;
    assign regBvalue = (read_regB == '0) ? '0 : w_fwd_b;

    // Count completed register writes, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_wb_count <= '0;
        else if (CONTROL_ENABLE_REG_WRITE)
            r_wb_count <= r_wb_count + 16'd1;
    end

    assign wb_count = r_wb_count;

endmodule

// File: tb/tb_lc2k_writeback.sv
// tb_lc2k_writeback: vector table plus write scoreboard for the writeback queue.
module tb_lc2k_writeback;
    import lc2k_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_dest;
    logic [31:0] in_value;
    logic        wb_stall;
    logic [2:0]  write_reg;
    logic [31:0] write_value;
    logic        CONTROL_ENABLE_REG_WRITE;
    logic [2:0]  read_regA;
    logic [2:0]  read_regB;
    logic [31:0] rf_valA;
    logic [31:0] rf_valB;
    logic [31:0] aluValA;
    logic [31:0] regBvalue;
    logic [1:0]  pending;
    logic [15:0] wb_count;

    always #5 clk = ~clk;

    lc2k_writeback #(.DATA_W(32), .DEPTH(2)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .in_dest                  (in_dest),
        .in_value                 (in_value),
        .wb_stall                 (wb_stall),
        .write_reg                (write_reg),
        .write_value              (write_value),
        .CONTROL_ENABLE_REG_WRITE (CONTROL_ENABLE_REG_WRITE),
        .read_regA                (read_regA),
        .read_regB                (read_regB),
        .rf_valA                  (rf_valA),
        .rf_valB                  (rf_valB),
        .aluValA                  (aluValA),
        .regBvalue                (regBvalue),
        .pending                  (pending),
        .wb_count                 (wb_count)
    );

    typedef struct {
        logic        vld;
        logic [2:0]  d;
        logic [31:0] val;
        logic        st;
        logic [2:0]  ra;
        logic [31:0] fa;
        logic [2:0]  rb;
        logic [31:0] fb;
        logic        er;
        logic [1:0]  ep;
        logic        es;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    localparam int N_BULK = 65529;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_wb = 16'd0;
    lc2k_entry_t sb[$];
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic [2:0] d, input logic [31:0] val,
                                input logic st, input logic [2:0] ra, input logic [31:0] fa,
                                input logic [2:0] rb, input logic [31:0] fb, input logic er,
                                input logic [1:0] ep, input logic es, input logic [31:0] ea,
                                input logic [31:0] eb);
        vec_t r;
        r.vld = vld; r.d = d; r.val = val; r.st = st; r.ra = ra; r.fa = fa;
        r.rb = rb; r.fb = fb; r.er = er; r.ep = ep; r.es = es; r.ea = ea; r.eb = eb;
        return r;
    endfunction

    function automatic logic [31:0] hmix(input logic [31:0] h, input logic [2:0] d, input logic [31:0] v);
        return {h[26:0], h[31:27]} ^ v ^ {d, 29'd0};
    endfunction

    task automatic drive(input vec_t r);
        in_valid = r.vld; in_dest = r.d; in_value = r.val; wb_stall = r.st;
        read_regA = r.ra; rf_valA = r.fa; read_regB = r.rb; rf_valB = r.fb;
    endtask

    // One cycle: drive, check just after the falling edge, then cross the rising edge.
    task automatic run(input vec_t r, input string tag);
        lc2k_entry_t e;
        drive(r);
        #1;
        chk({tag, "_ready"}, 32'(in_ready), 32'(r.er));
        chk({tag, "_pending"}, 32'(pending), 32'(r.ep));
        chk({tag, "_strobe"}, 32'(CONTROL_ENABLE_REG_WRITE), 32'(r.es));
        chk({tag, "_aluValA"}, aluValA, r.ea);
        chk({tag, "_regBvalue"}, regBvalue, r.eb);
        chk({tag, "_wb_count"}, 32'(wb_count), 32'(exp_wb));
        if (CONTROL_ENABLE_REG_WRITE) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_unexpected_strobe"}, 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_sb_write_reg"}, 32'(write_reg), 32'(e.dest));
                chk({tag, "_sb_write_value"}, write_value, e.value);
            end
        end
        if (r.vld && r.er && (r.d != 3'd0)) sb.push_back('{dest: r.d, value: r.val});
        if (r.es) exp_wb++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] h_exp;
        logic [31:0] h_obs;
        int          n_obs;
        h_exp = 32'd0;
        h_obs = 32'd0;
        n_obs = 0;
        reset = 1'b1;
        drive(mk(1, 3, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
        chk("rst_write_reg", 32'(write_reg), 32'd0);
        chk("rst_write_value", write_value, 32'd0);
        chk("rst_wb_count", 32'(wb_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // single write, full/stall ordering, forwarding, r0 entry
        tbl.push_back(mk(1, 3, 32'hAA, 0, 0, 32'h5, 0, 32'h6, 1, 0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 3, 32'h10, 3, 32'h20, 1, 1, 1, 32'hAA, 32'hAA));
        tbl.push_back(mk(0, 0, 32'h0, 0, 3, 32'h10, 4, 32'h44, 1, 0, 0, 32'h10, 32'h44));
        tbl.push_back(mk(1, 1, 32'h1, 1, 0, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 2, 32'h2, 1, 0, 32'h0, 0, 32'h0, 1, 1, 0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 3, 32'h3, 1, 0, 32'h0, 0, 32'h0, 0, 2, 0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 3, 32'h3, 0, 1, 32'h50, 2, 32'h60, 0, 2, 1, 32'h1, 32'h2));
        tbl.push_back(mk(1, 3, 32'h3, 0, 3, 32'h50, 2, 32'h60, 1, 1, 1, 32'h50, 32'h2));
        tbl.push_back(mk(0, 0, 32'h0, 0, 3, 32'h50, 2, 32'h60, 1, 1, 1, 32'h3, 32'h60));
        tbl.push_back(mk(0, 0, 32'h0, 0, 3, 32'h50, 0, 32'h60, 1, 0, 0, 32'h50, 32'h0));
        tbl.push_back(mk(1, 5, 32'h11, 1, 5, 32'h99, 6, 32'h77, 1, 0, 0, 32'h99, 32'h77));
        tbl.push_back(mk(1, 5, 32'h22, 1, 5, 32'h99, 6, 32'h77, 1, 1, 0, 32'h11, 32'h77));
        tbl.push_back(mk(0, 0, 32'h0, 1, 5, 32'h99, 6, 32'h77, 0, 2, 0, 32'h22, 32'h77));
        tbl.push_back(mk(0, 0, 32'h0, 1, 6, 32'h33, 5, 32'h99, 0, 2, 0, 32'h33, 32'h22));
        tbl.push_back(mk(0, 0, 32'h0, 0, 5, 32'h99, 5, 32'h98, 0, 2, 1, 32'h22, 32'h22));
        tbl.push_back(mk(0, 0, 32'h0, 0, 5, 32'h99, 5, 32'h98, 1, 1, 1, 32'h22, 32'h22));
        tbl.push_back(mk(0, 0, 32'h0, 0, 5, 32'h99, 5, 32'h98, 1, 0, 0, 32'h99, 32'h98));
        tbl.push_back(mk(1, 0, 32'hFFFF_FFFF, 0, 0, 32'h5, 0, 32'h7, 1, 0, 0, 32'h0, 32'h0));
        foreach (tbl[i]) run(tbl[i], $sformatf("row%0d", i));

        // r0 entry at the head: presented, popped, never strobed
        drive(mk(0, 0, 32'h0, 0, 0, 32'h5, 3, 32'h7, 0, 0, 0, 0, 0));
        #1;
        chk("r0_pending", 32'(pending), 32'd1);
        chk("r0_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
        chk("r0_write_reg", 32'(write_reg), 32'd0);
        chk("r0_write_value", write_value, 32'hFFFF_FFFF);
        chk("r0_aluValA", aluValA, 32'd0);
        chk("r0_regBvalue", regBvalue, 32'h7);
        @(posedge clk);
        @(negedge clk);
        run(mk(0, 0, 32'h0, 0, 0, 32'h5, 0, 32'h7, 1, 0, 0, 32'h0, 32'h0), "r0_after");

        // back-to-back stream up to wb_count 0xFFFF, order checked by a rolling hash
        for (int i = 0; i < N_BULK; i++) begin
            in_valid = 1'b1; wb_stall = 1'b0; read_regA = 3'd0; read_regB = 3'd0;
            in_dest = 3'((i % 7) + 1);
            in_value = 32'(i) * 32'h9E37 + 32'd1;
            h_exp = hmix(h_exp, in_dest, in_value);
            #1;
            if (CONTROL_ENABLE_REG_WRITE) begin
                h_obs = hmix(h_obs, write_reg, write_value);
                n_obs++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) begin
            #1;
            if (CONTROL_ENABLE_REG_WRITE) begin
                h_obs = hmix(h_obs, write_reg, write_value);
                n_obs++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        exp_wb = exp_wb + 16'(N_BULK);
        chk("bulk_write_count", 32'(n_obs), 32'(N_BULK));
        chk("bulk_order_hash", h_obs, h_exp);
        chk("bulk_wb_count", 32'(wb_count), 32'h0000_FFFF);

        // one more write wraps the counter to zero
        run(mk(1, 2, 32'hAB, 0, 2, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0), "wrap0");
        run(mk(0, 0, 32'h0, 0, 2, 32'h0, 0, 32'h0, 1, 1, 1, 32'hAB, 32'h0), "wrap1");
        run(mk(0, 0, 32'h0, 0, 2, 32'h0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0), "wrap2");

        // reset pulsed between edges with two stalled entries
        run(mk(1, 4, 32'h44, 1, 4, 32'h1, 0, 32'h0, 1, 0, 0, 32'h1, 32'h0), "mid0");
        run(mk(1, 6, 32'h66, 1, 4, 32'h1, 0, 32'h0, 1, 1, 0, 32'h44, 32'h0), "mid1");
        drive(mk(0, 0, 32'h0, 1, 4, 32'h1, 0, 32'h0, 0, 0, 0, 0, 0));
        #1;
        chk("mid_full_pending", 32'(pending), 32'd2);
        chk("mid_full_ready", 32'(in_ready), 32'd0);
        chk("mid_full_aluValA", aluValA, 32'h44);
        reset = 1'b1;
        #1;
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd0);
        chk("mid_rst_write_reg", 32'(write_reg), 32'd0);
        chk("mid_rst_write_value", write_value, 32'd0);
        chk("mid_rst_aluValA", aluValA, 32'h1);
        chk("mid_rst_wb_count", 32'(wb_count), 32'd0);
        reset = 1'b0;
        sb.delete();
        exp_wb = 16'd0;
        run(mk(1, 7, 32'h77, 0, 7, 32'h5, 4, 32'h9, 1, 0, 0, 32'h5, 32'h9), "post0");
        run(mk(0, 0, 32'h0, 0, 7, 32'h5, 4, 32'h9, 1, 1, 1, 32'h77, 32'h9), "post1");
        run(mk(0, 0, 32'h0, 0, 7, 32'h5, 4, 32'h9, 1, 0, 0, 32'h5, 32'h9), "post2");
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
